// File: rtl/wordlit_decode.sv
// rtl/wordlit_decode.sv - word-literal decoder with 2-entry output FIFO and saturating error counter
module wordlit_decode #(
  parameter logic [15:0] KEY   = 16'h0001,
  parameter int          ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [16:0]      __in0,
  input  logic             __in1,
  output logic [7:0]       __out0,
  output logic             __out1,
  output logic             __out2,
  output logic [ERR_W-1:0] __out3
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t             r_state;
  logic [7:0]         r_slot0;
  logic [7:0]         r_slot1;
  logic               r_out_valid;
  logic               r_in_ready;
  logic [ERR_W-1:0]   r_err;

  logic               w_in_valid;
  logic [15:0]        w_dec;
  logic               w_ok;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_err_inc;

  assign w_in_valid = __in0[16];
  assign w_dec      = __in0[15:0] ^ KEY;
  assign w_ok       = (w_dec[15:8] == 8'h00);
  assign w_accept   = w_in_valid && r_in_ready;
  assign w_push     = w_accept && w_ok;
  assign w_pop      = r_out_valid && __in1;
  assign w_err_inc  = w_accept && !w_ok && (r_err != {ERR_W{1'b1}});

  // r_slot0 is always the head; it is left untouched on the last pop so the output holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_slot0     <= 8'h00;
      r_slot1     <= 8'h00;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_err       <= '0;
    end else begin
      if (w_err_inc) r_err <= r_err + ERR_W'(1);
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_slot0     <= w_dec[7:0];
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_push && !w_pop) begin
            r_slot1     <= w_dec[7:0];
            r_state     <= S_TWO;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
          end else if (!w_push && w_pop) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end else if (w_push && w_pop) begin
            r_slot0     <= w_dec[7:0];
          end
        end
        S_TWO: begin
          if (w_pop) begin
            r_slot0     <= r_slot1;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign __out0 = r_slot0;
  assign __out1 = r_out_valid;
  assign __out2 = r_in_ready;
  assign __out3 = r_err;

endmodule

// File: tb/tb_wordlit_decode.sv
// tb/tb_wordlit_decode.sv - randomized and directed checks of wordlit_decode against a queue model
module tb_wordlit_decode;

  localparam logic [15:0] KEY = 16'h0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] in0;
  logic        in1;
  logic [7:0]  out0;
  logic        out1;
  logic        out2;
  logic [7:0]  out3;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  logic [7:0] m_last;
  int         m_err;

  wordlit_decode #(.KEY(KEY), .ERR_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .__in0  (in0),
    .__in1  (in1),
    .__out0 (out0),
    .__out1 (out1),
    .__out2 (out2),
    .__out3 (out3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] w, input logic rdy);
    rst = r;
    in0 = {v, w};
    in1 = rdy;
  endtask

  // Model: the FIFO is a queue; the decoded word is checked with plain arithmetic.
  task automatic tick();
    logic       acc;
    logic       pop;
    logic [15:0] w;
    acc = in0[16] && (mq.size() < 2);
    pop = (mq.size() > 0) && in1;
    w   = in0[15:0] ^ KEY;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_last = 8'h00;
      m_err  = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (w < 16'h0100) mq.push_back(w[7:0]);
        else if (m_err < 255) m_err++;
      end
      if (mq.size() > 0) m_last = mq[0];
    end
    chk("out_valid", 32'(out1), 32'(mq.size() > 0));
    chk("in_ready",  32'(out2), 32'(mq.size() < 2));
    chk("out_byte",  32'(out0), 32'(m_last));
    chk("err_count", 32'(out3), 32'(m_err));
  endtask

  initial begin
    m_last = 8'h00;
    m_err  = 0;

    drive(1, 1, 16'hFFFF, 0);
    tick();
    tick();
    chk("reset_err", 32'(out3), 32'h0);
    chk("reset_valid", 32'(out1), 32'h0);

    drive(0, 1, 16'h0042, 1);
    tick();
    chk("single_valid", 32'(out1), 32'h1);
    chk("single_byte", 32'(out0), 32'h43);
    drive(0, 0, 16'h0000, 1);
    tick();
    chk("single_drained", 32'(out1), 32'h0);

    drive(0, 1, 16'h0001, 0);
    tick();
    drive(0, 1, 16'h00FF, 0);
    tick();
    chk("fill_in_ready", 32'(out2), 32'h0);
    chk("fill_head", 32'(out0), 32'h00);
    drive(0, 1, 16'h0010, 0);
    tick();
    chk("full_head_kept", 32'(out0), 32'h00);
    drive(0, 0, 16'h0000, 1);
    tick();
    chk("drain_second", 32'(out0), 32'hFE);
    chk("drain_ready", 32'(out2), 32'h1);
    tick();
    chk("drain_empty", 32'(out1), 32'h0);

    drive(0, 1, 16'h0100, 1);
    tick();
    drive(0, 1, 16'hFF01, 1);
    tick();
    drive(0, 1, 16'h1234, 1);
    tick();
    chk("malformed_count", 32'(out3), 32'd3);
    chk("malformed_no_valid", 32'(out1), 32'h0);

    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 16'hA5A5, 1);
      tick();
    end
    chk("err_saturated", 32'(out3), 32'hFF);

    drive(0, 1, 16'h0010, 0);
    tick();
    chk("pushpop_head0", 32'(out0), 32'h11);
    drive(0, 1, 16'h0020, 1);
    tick();
    chk("pushpop_head1", 32'(out0), 32'h21);
    chk("pushpop_one", 32'(out2), 32'h1);
    drive(0, 0, 16'h0000, 1);
    tick();

    drive(1, 0, 16'h0000, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 16'h0F00, 0);
      tick();
    end
    drive(0, 1, 16'h0002, 0);
    tick();
    drive(0, 1, 16'h0004, 0);
    tick();
    chk("pre_rst_full", 32'(out2), 32'h0);
    chk("pre_rst_err", 32'(out3), 32'd5);
    drive(1, 1, 16'h0032, 1);
    tick();
    chk("rst_mid_valid", 32'(out1), 32'h0);
    chk("rst_mid_ready", 32'(out2), 32'h1);
    chk("rst_mid_err", 32'(out3), 32'h0);
    drive(0, 0, 16'h0000, 1);
    tick();
    chk("rst_mid_nothing", 32'(out1), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] w;
      w = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {8'h00, 8'($urandom)};
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), w,
            ($urandom_range(0, 2) != 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wordlit_decode.md
Name: wordlit_decode

Overview:
- Inverse of the 8-to-16 word-literal encoder stage (encoder out = zero-extend(byte) XOR 16'h0001).
- Accepts 16-bit encoded words, checks that the upper byte is zero, and recovers the original byte by XORing with the key.
- Recovered bytes are buffered in a 2-entry FIFO with a valid/ready output handshake.
- Malformed words are dropped and counted; the block sits on the receive side of the encoder's stream.

Parameters:
- KEY, 16'h0001, XOR key; must match the encoder.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- __in0  input  17  {in_valid[16], in_word[15:0]}; encoded word offered this cycle
- __in1  input  1  out_ready; downstream accepts the __out0 byte this cycle
- __out0  output  8  out_byte; head-of-FIFO decoded byte
- __out1  output  1  out_valid; FIFO non-empty
- __out2  output  1  in_ready; FIFO has room (fewer than 2 entries)
- __out3  output  ERR_W  err_count; saturating count of malformed words

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high.
  - rst wins over every other event in the same cycle.
- Reset values:
  - __out0 = 8'h00, __out1 = 0, __out2 = 1, __out3 = 0.
  - FIFO state = EMPTY; both FIFO slots = 8'h00.
- Accept:
  - An input word is accepted when in_valid && in_ready at the clock edge.
  - in_ready is a function of registered state only: 1 in EMPTY and ONE, 0 in TWO. It has no combinational path from __in0 or __in1.
  - in_word is ignored when in_valid=0 or in_ready=0.
- Decode of an accepted word:
  - Compute w = in_word XOR KEY.
  - Well-formed when w[15:8] == 8'h00. The decoded byte w[7:0] is pushed into the FIFO.
  - Malformed otherwise. Nothing is pushed; err_count increments by 1.
  - err_count saturates at 2^ERR_W-1 and never wraps.
- Pop: occurs when out_valid && out_ready at the clock edge. __out0 is the head entry whenever out_valid=1.
- State machine (FIFO occupancy):
  - EMPTY: push -> ONE.
  - ONE:
    - push only -> TWO.
    - pop only -> EMPTY.
    - push and pop together -> ONE; the new byte becomes the head.
  - TWO:
    - pop -> ONE; the second entry becomes the head.
    - Push is impossible because in_ready=0.
  - A malformed accepted word counts as no push in all of the above.
- Latency:
  - Accepted well-formed word -> out_valid=1 with that byte on the next cycle (1-cycle latency).
  - Sustained throughput is 1 word/cycle while out_ready is held high.
- Ordering: bytes leave in acceptance order; no reordering or duplication.
- Pop with out_valid=0: ignored.
- __out0 when out_valid=0: holds the last head value (reset value 8'h00); consumers must not sample it.
- Reset mid-operation: a FIFO holding data is cleared in one cycle. No byte accepted before the reset edge appears after it. err_count clears to 0.

Test Plan:
- Reset, then idle: assert rst for 2 cycles with __in0=17'h1_FFFF -> outputs at reset values, err_count=0, nothing accepted.
- Single decode: in_word=16'h0042 with in_valid=1, out_ready=1 -> next cycle out_valid=1, __out0=8'h43; the cycle after, out_valid=0.
- Backpressure fill: out_ready=0, push 16'h0001 then 16'h00FF -> after 2 cycles in_ready=0, out_valid=1, __out0=8'h00. A third word 16'h0010 offered now is not accepted.
  - Then raise out_ready: bytes 8'h00 then 8'hFE appear on consecutive cycles, and in_ready returns to 1.
- Malformed and saturation with ERR_W=8: send 16'h0100, 16'hFF01, 16'h1234 -> no out_valid, err_count=3.
  - Force 300 malformed words -> err_count stays at 8'hFF.
- Simultaneous push/pop in ONE: head=8'h11 (from 16'h0010); same cycle pop and push 16'h0020 -> next cycle still ONE, __out0=8'h21.
- Reset mid-operation: FIFO in TWO, err_count=5; pulse rst for 1 cycle together with in_valid=1 -> next cycle out_valid=0, in_ready=1, err_count=0, and the word offered during reset is not accepted.
